// File: rtl/encoders_events_pkg.sv
// encoders_events_pkg: event word layout and arithmetic helpers
// shared by the encoder event scheduler and its bench.
package encoders_events_pkg;

    localparam int POS_BITS = 4;
    localparam int ACC_BITS = 8;

    typedef struct packed {
        logic [3:0]          ch;
        logic                btn;
        logic                toggled;
        logic                sat;
        logic                rsvd;
        logic [ACC_BITS-1:0] acc_p;
        logic [ACC_BITS-1:0] acc_n;
        logic [7:0]          tick;
    } enc_event_t;

    typedef struct packed {
        logic                sat;
        logic [ACC_BITS-1:0] val;
    } sat_res_t;

    // Modular step between two position counters, read as signed.
    function automatic logic signed [POS_BITS-1:0] pos_delta(
        input logic [POS_BITS-1:0] old_pos,
        input logic [POS_BITS-1:0] new_pos
    );
        return new_pos - old_pos;
    endfunction

    // Signed accumulate, clamped to -128..+127 with a saturation flag.
    function automatic sat_res_t sat_add8(
        input logic [ACC_BITS-1:0] acc,
        input logic [POS_BITS-1:0] d
    );
        logic [ACC_BITS:0] s;
        sat_res_t          r;
        s = {acc[ACC_BITS-1], acc}
          + {{(ACC_BITS+1-POS_BITS){d[POS_BITS-1]}}, d};
        r.sat = s[ACC_BITS] ^ s[ACC_BITS-1];
        if (r.sat)
            r.val = s[ACC_BITS] ? 8'h80 : 8'h7F;
        else
            r.val = s[ACC_BITS-1:0];
        return r;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous FIFO with a registered head word
// that reads as zero while empty.
module event_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd, w_rd_inc;
    logic [AW:0]      r_count, w_count_nx;
    logic [WIDTH-1:0] r_head, w_head_nx;
    logic             r_valid, w_do_push, w_do_pop;

    assign w_do_pop  = i_pop & r_valid;
    assign w_do_push = i_push & ((r_count != FULL) | w_do_pop);
    assign w_rd_inc  = r_rd + 1'b1;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_nx = r_count;
        if (w_do_push & ~w_do_pop)
            w_count_nx = r_count + 1'b1;
        else if (~w_do_push & w_do_pop)
            w_count_nx = r_count - 1'b1;
    end

    // Next head: bypass the push when the queue is (about to be) empty.
    always_comb begin
        w_head_nx = r_head;
        if (w_count_nx == '0)
            w_head_nx = '0;
        else if (!r_valid || (w_do_pop && r_count == (AW+1)'(1)))
            w_head_nx = i_data;
        else if (w_do_pop)
            w_head_nx = r_mem[w_rd_inc];
    end

    // Storage array; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push)
            r_mem[r_wr] <= i_data;
    end

    // Pointers, count and registered head.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_head  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_do_push)
                r_wr <= r_wr + 1'b1;
            if (w_do_pop)
                r_rd <= w_rd_inc;
            r_count <= w_count_nx;
            r_head  <= w_head_nx;
            r_valid <= (w_count_nx != '0);
        end
    end

    assign o_head  = r_head;
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/encoders_event_scheduler.sv
// encoders_event_scheduler: diffs encoder/button snapshots into
// per-channel deltas and queues round-robin change events.
module encoders_event_scheduler
    import encoders_events_pkg::*;
#(
    parameter int ENCODER_COUNT = 5,
    parameter int BUTTON_COUNT  = 1,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    input  logic                          UPDATED,
    input  logic [16*ENCODER_COUNT-1:0]   ENCODERS_FLAT,
    input  logic [8*BUTTON_COUNT-1:0]     BUTTONS_FLAT,
    input  logic                          EVT_POP,
    input  logic                          IRQ_EN,
    output logic                          EVT_VALID,
    output logic [31:0]                   EVT_DATA,
    output logic [$clog2(FIFO_DEPTH):0]   EVT_COUNT,
    output logic                          IRQ,
    output logic                          OVERFLOW
);
    localparam int NCH = ENCODER_COUNT + BUTTON_COUNT;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [NCH-1:0][3:0] w_new_n, w_new_p, r_snap_n, r_snap_p;
    logic [NCH-1:0]      w_new_b, r_snap_b;
    logic [NCH-1:0][7:0] r_acc_n, r_acc_p;
    logic [NCH-1:0]      r_tog, r_sat, r_pend;
    logic [NCH-1:0]      w_hit, w_tog_nx, w_sat_nx, w_pend_nx, w_sat_now;
    sat_res_t [NCH-1:0]  w_rn, w_rp;
    logic [IW-1:0]       r_rr, w_gnt_idx, w_idx;
    logic [IW:0]         w_sum;
    logic [7:0]          r_tick;
    logic                r_primed, r_irq, r_ovf;
    logic                w_upd, w_room, w_gnt_any, w_gnt;
    enc_event_t          w_evt;
    logic                w_fifo_valid;
    logic [31:0]         w_fifo_data;
    logic [CW-1:0]       w_fifo_count;
    logic [7*ENCODER_COUNT-1:0] w_unused_edur;
    logic [7*BUTTON_COUNT-1:0]  w_unused_bdur;

    for (genvar e = 0; e < ENCODER_COUNT; e++) begin : g_enc
        assign w_new_n[e] = ENCODERS_FLAT[16*e +: 4];
        assign w_new_p[e] = ENCODERS_FLAT[16*e+4 +: 4];
        assign w_new_b[e] = ENCODERS_FLAT[16*e+15];
        assign w_unused_edur[7*e +: 7] = ENCODERS_FLAT[16*e+8 +: 7];
    end

    // Buttons have no position: their deltas are forced to zero.
    for (genvar b = 0; b < BUTTON_COUNT; b++) begin : g_btn
        assign w_new_n[ENCODER_COUNT+b] = r_snap_n[ENCODER_COUNT+b];
        assign w_new_p[ENCODER_COUNT+b] = r_snap_p[ENCODER_COUNT+b];
        assign w_new_b[ENCODER_COUNT+b] = BUTTONS_FLAT[8*b+7];
        assign w_unused_bdur[7*b +: 7]  = BUTTONS_FLAT[8*b +: 7];
    end

    assign w_upd  = UPDATED & r_primed;
    assign w_room = (w_fifo_count != CW'(FIFO_DEPTH))
                  | (EVT_POP & w_fifo_valid);
    assign w_gnt  = w_gnt_any & w_room;

    // Round-robin search from RR+1; nearest pending channel wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = r_rr;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = NCH; k >= 1; k--) begin
            w_sum = (IW+1)'(r_rr) + (IW+1)'(k);
            w_idx = (w_sum >= (IW+1)'(NCH))
                  ? IW'(w_sum - (IW+1)'(NCH)) : IW'(w_sum);
            if (r_pend[w_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    // Per-channel next state; a granted channel restarts from zero.
    always_comb begin
        w_hit     = '0;
        w_rn      = '0;
        w_rp      = '0;
        w_tog_nx  = '0;
        w_sat_nx  = '0;
        w_pend_nx = '0;
        w_sat_now = '0;
        for (int c = 0; c < NCH; c++) begin
            w_hit[c] = w_gnt & (w_gnt_idx == IW'(c));
            w_rn[c]  = sat_add8(w_hit[c] ? 8'h00 : r_acc_n[c],
                                pos_delta(r_snap_n[c], w_new_n[c]));
            w_rp[c]  = sat_add8(w_hit[c] ? 8'h00 : r_acc_p[c],
                                pos_delta(r_snap_p[c], w_new_p[c]));
            w_sat_now[c] = w_rn[c].sat | w_rp[c].sat;
            w_tog_nx[c]  = (~w_hit[c] & r_tog[c])
                         ^ (w_new_b[c] ^ r_snap_b[c]);
            w_sat_nx[c]  = (~w_hit[c] & r_sat[c]) | w_sat_now[c];
            w_pend_nx[c] = (|w_rn[c].val) | (|w_rp[c].val)
                         | w_tog_nx[c];
        end
    end

    // Event word for the granted channel, pre-update values.
    always_comb begin
        w_evt         = '0;
        w_evt.ch      = 4'(w_gnt_idx);
        w_evt.btn     = r_snap_b[w_gnt_idx];
        w_evt.toggled = r_tog[w_gnt_idx];
        w_evt.sat     = r_sat[w_gnt_idx];
        w_evt.acc_p   = r_acc_p[w_gnt_idx];
        w_evt.acc_n   = r_acc_n[w_gnt_idx];
        w_evt.tick    = r_tick;
    end

    // Snapshots, priming, tick counter and round-robin pointer.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_snap_n <= '0;
            r_snap_p <= '0;
            r_snap_b <= '0;
            r_primed <= 1'b0;
            r_tick   <= '0;
            r_rr     <= '0;
        end else begin
            if (UPDATED) begin
                r_snap_n <= w_new_n;
                r_snap_p <= w_new_p;
                r_snap_b <= w_new_b;
                r_primed <= 1'b1;
            end
            if (w_upd)
                r_tick <= r_tick + 8'd1;
            if (w_gnt)
                r_rr <= w_gnt_idx;
        end
    end

    // Accumulators: fold in deltas on a strobe, else clear on grant.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_acc_n <= '0;
            r_acc_p <= '0;
            r_tog   <= '0;
            r_sat   <= '0;
            r_pend  <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_upd) begin
                    r_acc_n[c] <= w_rn[c].val;
                    r_acc_p[c] <= w_rp[c].val;
                    r_tog[c]   <= w_tog_nx[c];
                    r_sat[c]   <= w_sat_nx[c];
                    r_pend[c]  <= w_pend_nx[c];
                end else if (w_hit[c]) begin
                    r_acc_n[c] <= '0;
                    r_acc_p[c] <= '0;
                    r_tog[c]   <= 1'b0;
                    r_sat[c]   <= 1'b0;
                    r_pend[c]  <= 1'b0;
                end
            end
        end
    end

    // Interrupt tracks queue state; overflow is sticky until reset.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_irq <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_irq <= IRQ_EN & w_fifo_valid;
            if (w_upd & (|w_sat_now))
                r_ovf <= 1'b1;
        end
    end

    event_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESETN),
        .i_push  (w_gnt),
        .i_data  (w_evt),
        .i_pop   (EVT_POP),
        .o_head  (w_fifo_data),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign EVT_VALID = w_fifo_valid;
    assign EVT_DATA  = w_fifo_data;
    assign EVT_COUNT = w_fifo_count;
    assign IRQ       = r_irq;
    assign OVERFLOW  = r_ovf;

endmodule

// File: tb/tb_encoders_event_scheduler.sv
// tb_encoders_event_scheduler: directed stimulus with an event
// scoreboard for the encoder event scheduler.
module tb_encoders_event_scheduler;

    logic        CLK           = 1'b0;
    logic        RESETN        = 1'b0;
    logic        UPDATED       = 1'b0;
    logic [79:0] ENCODERS_FLAT = '0;
    logic [7:0]  BUTTONS_FLAT  = '0;
    logic        EVT_POP       = 1'b0;
    logic        IRQ_EN        = 1'b0;
    logic        EVT_VALID;
    logic [31:0] EVT_DATA;
    logic [4:0]  EVT_COUNT;
    logic        IRQ;
    logic        OVERFLOW;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] sb [$];
    logic [3:0]  pn [5];
    logic [3:0]  pp [5];
    logic        bt;
    int          tick;
    bit          primed;

    encoders_event_scheduler dut (
        .CLK           (CLK),
        .RESETN        (RESETN),
        .UPDATED       (UPDATED),
        .ENCODERS_FLAT (ENCODERS_FLAT),
        .BUTTONS_FLAT  (BUTTONS_FLAT),
        .EVT_POP       (EVT_POP),
        .IRQ_EN        (IRQ_EN),
        .EVT_VALID     (EVT_VALID),
        .EVT_DATA      (EVT_DATA),
        .EVT_COUNT     (EVT_COUNT),
        .IRQ           (IRQ),
        .OVERFLOW      (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] ev(input int c, input bit b,
                                       input bit tg, input bit st,
                                       input logic [7:0] ap,
                                       input logic [7:0] an,
                                       input int t);
        return {4'(c), b, tg, st, 1'b0, ap, an, 8'(t)};
    endfunction

    task automatic strobe();
        for (int e = 0; e < 5; e++)
            ENCODERS_FLAT[16*e +: 16] = {1'b0, 7'($urandom), pp[e], pn[e]};
        BUTTONS_FLAT = {bt, 7'($urandom)};
        UPDATED = 1'b1;
        step(1);
        UPDATED = 1'b0;
        if (primed)
            tick++;
        primed = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] want;
        int          w;
        w = 0;
        while (!EVT_VALID && w < 50) begin
            step(1);
            w++;
        end
        want = (sb.size() != 0) ? sb.pop_front() : 32'hFFFF_FFFF;
        chk({tag, "_valid"}, 32'(EVT_VALID), 32'd1);
        chk(tag, EVT_DATA, want);
        if (EVT_VALID) begin
            EVT_POP = 1'b1;
            step(1);
            EVT_POP = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int e = 0; e < 5; e++) begin
            pn[e] = '0;
            pp[e] = '0;
        end
        bt     = 1'b0;
        tick   = 0;
        primed = 1'b0;

        step(2);
        chk("rst_valid", 32'(EVT_VALID), 32'd0);
        chk("rst_data", EVT_DATA, 32'd0);
        chk("rst_count", 32'(EVT_COUNT), 32'd0);
        chk("rst_irq", 32'(IRQ), 32'd0);
        chk("rst_ovf", 32'(OVERFLOW), 32'd0);
        RESETN = 1'b1;
        step(1);

        // priming strobe makes no event; next one reports +2
        pn[0] = 4'd3;
        strobe();
        step(3);
        chk("prime_count", 32'(EVT_COUNT), 32'd0);
        pn[0] = 4'd5;
        strobe();
        sb.push_back(ev(0, 0, 0, 0, 8'h00, 8'h02, tick));
        pop_check("t1_ch0");

        // pos_n wraparound both ways on channel 2
        pn[2] = 4'd15;
        strobe();
        sb.push_back(ev(2, 0, 0, 0, 8'h00, 8'hFF, tick));
        pop_check("t2_m1");
        pn[2] = 4'd1;
        strobe();
        sb.push_back(ev(2, 0, 0, 0, 8'h00, 8'h02, tick));
        pop_check("t2_wrap_p2");
        pn[2] = 4'd14;
        strobe();
        sb.push_back(ev(2, 0, 0, 0, 8'h00, 8'hFD, tick));
        pop_check("t2_wrap_m3");

        // park RR on 1, then 1/3/5 pending together
        pn[1] = 4'd1;
        strobe();
        sb.push_back(ev(1, 0, 0, 0, 8'h00, 8'h01, tick));
        pop_check("t3_rr1");
        pp[1] = 4'd1;
        pn[3] = 4'd2;
        bt    = 1'b1;
        strobe();
        sb.push_back(ev(3, 0, 0, 0, 8'h00, 8'h02, tick));
        sb.push_back(ev(5, 1, 1, 0, 8'h00, 8'h00, tick));
        sb.push_back(ev(1, 0, 0, 0, 8'h01, 8'h00, tick));
        step(3);
        chk("t3_count", 32'(EVT_COUNT), 32'd3);
        pop_check("t3_g3");
        pop_check("t3_g5");
        pop_check("t3_g1");

        // fill the FIFO from channel 0
        for (int i = 0; i < 16; i++) begin
            pn[0] = pn[0] + 4'd1;
            strobe();
            sb.push_back(ev(0, 0, 0, 0, 8'h00, 8'h01, tick));
            step(1);
        end
        step(1);
        chk("t4_full", 32'(EVT_COUNT), 32'd16);

        // blocked: enc4 saturates, button toggles cancel
        for (int i = 0; i < 20; i++) begin
            pn[4] = pn[4] + 4'd7;
            strobe();
        end
        bt = 1'b0;
        strobe();
        bt = 1'b1;
        strobe();
        step(2);
        chk("t4_nopush", 32'(EVT_COUNT), 32'd16);
        chk("t4_ovf", 32'(OVERFLOW), 32'd1);
        sb.push_back(ev(4, 0, 0, 1, 8'h00, 8'h7F, tick));
        pop_check("t4_pop0");
        chk("t4_popfull", 32'(EVT_COUNT), 32'd16);
        for (int i = 0; i < 16; i++)
            pop_check("t4_drain");
        step(5);
        chk("t5_cancel_cnt", 32'(EVT_COUNT), 32'd0);
        chk("t5_cancel_vld", 32'(EVT_VALID), 32'd0);
        chk("t5_ovf_sticky", 32'(OVERFLOW), 32'd1);

        // single button toggles each produce an event
        bt = 1'b0;
        strobe();
        sb.push_back(ev(5, 0, 1, 0, 8'h00, 8'h00, tick));
        pop_check("t5_tog_off");
        bt = 1'b1;
        strobe();
        sb.push_back(ev(5, 1, 1, 0, 8'h00, 8'h00, tick));
        pop_check("t5_tog_on");

        // IRQ timing relative to EVT_VALID
        IRQ_EN = 1'b1;
        pn[3]  = 4'd4;
        strobe();
        sb.push_back(ev(3, 0, 0, 0, 8'h00, 8'h02, tick));
        step(1);
        chk("t6_valid", 32'(EVT_VALID), 32'd1);
        chk("t6_irq_lag", 32'(IRQ), 32'd0);
        step(1);
        chk("t6_irq_on", 32'(IRQ), 32'd1);
        pop_check("t6_evt");
        chk("t6_empty", 32'(EVT_VALID), 32'd0);
        chk("t6_irq_hold", 32'(IRQ), 32'd1);
        step(1);
        chk("t6_irq_off", 32'(IRQ), 32'd0);

        // reset with two events queued
        pn[3] = 4'd6;
        pn[1] = 4'd3;
        strobe();
        step(3);
        chk("t6_queued", 32'(EVT_COUNT), 32'd2);
        RESETN = 1'b0;
        step(1);
        chk("t6r_valid", 32'(EVT_VALID), 32'd0);
        chk("t6r_data", EVT_DATA, 32'd0);
        chk("t6r_count", 32'(EVT_COUNT), 32'd0);
        chk("t6r_irq", 32'(IRQ), 32'd0);
        chk("t6r_ovf", 32'(OVERFLOW), 32'd0);
        sb.delete();
        tick   = 0;
        primed = 1'b0;
        RESETN = 1'b1;
        step(1);
        pn[2] = 4'd7;
        strobe();
        step(3);
        chk("t6_reprime", 32'(EVT_COUNT), 32'd0);
        pn[2] = 4'd8;
        strobe();
        sb.push_back(ev(2, 0, 0, 0, 8'h00, 8'h01, tick));
        pop_check("t6_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
